// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - byte input and decoded-command output bundle for the UART command parser
interface uart_cmd_parser_if #(
    parameter int MAX_LEN = 4
);
    logic                   rx_done;
    logic [7:0]             rx_data;
    logic                   cmd_valid;
    logic [7:0]             cmd_code;
    logic [2:0]             cmd_len;
    logic [8*MAX_LEN-1:0]   cmd_payload;
    logic                   frame_error;
    logic                   busy;

    modport master (
        output rx_done, rx_data,
        input  cmd_valid, cmd_code, cmd_len, cmd_payload, frame_error, busy
    );

    modport slave (
        input  rx_done, rx_data,
        output cmd_valid, cmd_code, cmd_len, cmd_payload, frame_error, busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed command decoder: AA, cmd, len, payload, XOR checksum, with inter-byte timeout
module uart_cmd_parser #(
    parameter int CLOCK_HZ       = 50_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int MAX_LEN        = 4
) (
    input  logic               clk,
    input  logic               reset,
    uart_cmd_parser_if.slave   bus
);

    localparam int             CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMO = CW'(TIMEOUT_CYCLES);
    localparam int             PW  = 8 * MAX_LEN;

    // cmd_len is 3 bits wide, so payloads longer than 7 bytes cannot be reported
    if (CLOCK_HZ < 1 || TIMEOUT_CYCLES < 1 || MAX_LEN < 1 || MAX_LEN > 7) begin : g_param_check
        $error("uart_cmd_parser: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      chk_q, chk_d;
    logic [7:0]      pend_cmd_q, pend_cmd_d;
    logic [2:0]      pend_len_q, pend_len_d;
    logic [PW-1:0]   pend_pay_q, pend_pay_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      cmd_code_q, cmd_code_d;
    logic [2:0]      cmd_len_q, cmd_len_d;
    logic [PW-1:0]   cmd_pay_q, cmd_pay_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            frame_error_q, frame_error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            chk_q         <= '0;
            pend_cmd_q    <= '0;
            pend_len_q    <= '0;
            pend_pay_q    <= '0;
            idx_q         <= '0;
            cmd_code_q    <= '0;
            cmd_len_q     <= '0;
            cmd_pay_q     <= '0;
            cmd_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            chk_q         <= chk_d;
            pend_cmd_q    <= pend_cmd_d;
            pend_len_q    <= pend_len_d;
            pend_pay_q    <= pend_pay_d;
            idx_q         <= idx_d;
            cmd_code_q    <= cmd_code_d;
            cmd_len_q     <= cmd_len_d;
            cmd_pay_q     <= cmd_pay_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        chk_d         = chk_q;
        pend_cmd_d    = pend_cmd_q;
        pend_len_d    = pend_len_q;
        pend_pay_d    = pend_pay_q;
        idx_d         = idx_q;
        cmd_code_d    = cmd_code_q;
        cmd_len_d     = cmd_len_q;
        cmd_pay_d     = cmd_pay_q;
        cmd_valid_d   = 1'b0;
        frame_error_d = 1'b0;

        // Saturating idle counter; the limit value itself is the last cycle a byte may still arrive
        if (state_q == S_IDLE || bus.rx_done) begin
            cnt_d = '0;
        end else if (cnt_q != TMO) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.rx_done && bus.rx_data == 8'hAA) begin
                    pend_pay_d = '0;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.rx_done) begin
                    pend_cmd_d = bus.rx_data;
                    chk_d      = bus.rx_data;
                    state_d    = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.rx_done) begin
                    chk_d = chk_q ^ bus.rx_data;
                    if (bus.rx_data > 8'(MAX_LEN)) begin
                        frame_error_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        pend_len_d = bus.rx_data[2:0];
                        idx_d      = '0;
                        state_d    = (bus.rx_data == 8'd0) ? S_CHECK : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.rx_done) begin
                    chk_d = chk_q ^ bus.rx_data;
                    for (int k = 0; k < MAX_LEN; k++) begin
                        if (idx_q == 3'(k)) begin
                            pend_pay_d[8*k +: 8] = bus.rx_data;
                        end
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == pend_len_q - 3'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (bus.rx_done) begin
                    if (bus.rx_data == chk_q) begin
                        cmd_code_d  = pend_cmd_q;
                        cmd_len_d   = pend_len_q;
                        cmd_pay_d   = pend_pay_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !bus.rx_done && cnt_q == TMO) begin
            frame_error_d = 1'b1;
            state_d       = S_IDLE;
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.cmd_code    = cmd_code_q;
    assign bus.cmd_len     = cmd_len_q;
    assign bus.cmd_payload = cmd_pay_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int T    = 20;
    localparam int MLEN = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        bit          err;
        logic [7:0]  code;
        logic [2:0]  len;
        logic [31:0] pay;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    uart_cmd_parser_if #(.MAX_LEN(MLEN)) bus ();

    uart_cmd_parser #(
        .CLOCK_HZ       (50_000_000),
        .TIMEOUT_CYCLES (T),
        .MAX_LEN        (MLEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input bit err, input logic [7:0] c, input logic [2:0] l,
                                input logic [31:0] p);
        exp_t e;
        e.err  = err;
        e.code = c;
        e.len  = l;
        e.pay  = p;
        e.due  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.cmd_valid === 1'b1 && bus.frame_error === 1'b1)
            check("both_pulses", 1, 0);
        if (bus.cmd_valid === 1'b1 || bus.frame_error === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {bus.cmd_valid, bus.frame_error}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_err", bus.frame_error, e.err);
                check("pulse_cycle", cyc, e.due);
                if (!e.err) begin
                    check("cmd_code", bus.cmd_code, e.code);
                    check("cmd_len", bus.cmd_len, e.len);
                    check("cmd_payload", bus.cmd_payload, e.pay);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("missing_pulse", 0, 1);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last, input exp_t e);
        exp_t ee;
        @(negedge clk);
        if (last) begin
            ee     = e;
            ee.due = cyc + 1;
            exp_q.push_back(ee);
        end
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    task automatic send_seq(input logic [7:0] bs[$], input bit has_exp, input exp_t e);
        for (int i = 0; i < bs.size(); i++)
            send_byte(bs[i], has_exp && (i == bs.size() - 1), e);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] c, input logic [2:0] l,
                                 input logic [31:0] p);
        check({tag, "_code"}, bus.cmd_code, c);
        check({tag, "_len"}, bus.cmd_len, l);
        check({tag, "_payload"}, bus.cmd_payload, p);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_valid"}, bus.cmd_valid, 0);
        check({tag, "_ferr"}, bus.frame_error, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check_outputs(tag, 8'h00, 3'd0, 32'h0);
        reset = 1'b0;
    endtask

    logic [7:0]  bq[$];
    exp_t        none;
    logic [7:0]  code, b, chk;
    logic [2:0]  len;
    logic [31:0] pay;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        none        = mk(0, 8'h00, 3'd0, 32'h0);

        do_reset("reset");

        bq = '{8'hAA, 8'h10, 8'h02, 8'h34, 8'h56, 8'h70};
        send_seq(bq, 1, mk(0, 8'h10, 3'd2, 32'h0000_5634));
        repeat (2) @(negedge clk);

        bq = '{8'hAA, 8'h10, 8'h02, 8'h34, 8'h56, 8'h71};
        send_seq(bq, 1, mk(1, 8'h00, 3'd0, 32'h0));
        repeat (2) @(negedge clk);
        check_outputs("hold_after_chk_err", 8'h10, 3'd2, 32'h0000_5634);

        bq = '{8'h55, 8'hAA, 8'h20, 8'h00, 8'h20};
        send_seq(bq, 1, mk(0, 8'h20, 3'd0, 32'h0));
        repeat (2) @(negedge clk);

        send_byte(8'hAA, 0, none);
        check("busy_after_sync", bus.busy, 1);
        bq = '{8'h10, 8'h05};
        send_seq(bq, 1, mk(1, 8'h00, 3'd0, 32'h0));
        check("busy_after_len_err", bus.busy, 0);
        check_outputs("hold_after_len_err", 8'h20, 3'd0, 32'h0);

        bq = '{8'hAA, 8'h30, 8'h01, 8'hAA, 8'h9B};
        send_seq(bq, 1, mk(0, 8'h30, 3'd1, 32'h0000_00AA));
        repeat (2) @(negedge clk);

        bq = '{8'hAA, 8'h10};
        send_seq(bq, 0, none);
        begin
            exp_t e;
            e     = mk(1, 8'h00, 3'd0, 32'h0);
            e.due = cyc + T + 1;
            exp_q.push_back(e);
        end
        repeat (T + 5) @(negedge clk);
        check("busy_after_timeout", bus.busy, 0);
        check_outputs("hold_after_timeout", 8'h30, 3'd1, 32'h0000_00AA);

        bq = '{8'hAA, 8'h10};
        send_seq(bq, 0, none);
        repeat (T - 1) @(negedge clk);
        bq = '{8'h02, 8'h34, 8'h56, 8'h70};
        send_seq(bq, 1, mk(0, 8'h10, 3'd2, 32'h0000_5634));
        repeat (2) @(negedge clk);

        for (int f = 0; f < 5; f++) begin
            len  = 3'($urandom_range(0, MLEN));
            code = 8'($urandom);
            bq   = '{8'hAA, code, {5'd0, len}};
            chk  = code ^ {5'd0, len};
            pay  = '0;
            for (int k = 0; k < int'(len); k++) begin
                b = 8'($urandom);
                bq.push_back(b);
                chk ^= b;
                pay[8*k +: 8] = b;
            end
            bq.push_back(chk);
            send_seq(bq, 1, mk(0, code, len, pay));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        bq = '{8'hAA, 8'h10, 8'h02, 8'h34};
        send_seq(bq, 0, none);
        repeat (2) @(negedge clk);
        do_reset("reset_mid_frame");
        bq = '{8'hAA, 8'h10, 8'h02, 8'h34, 8'h56, 8'h70};
        send_seq(bq, 1, mk(0, 8'h10, 3'd2, 32'h0000_5634));

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, meaning system clock frequency.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5_000_000, meaning maximum idle cycles between bytes of one frame (100 ms at 50 MHz).
REQ-003 SHALL have parameter MAX_LEN, default 4, meaning maximum payload bytes per frame.
REQ-004 SHALL have port clk  in  1  system clock; reset is reset, synchronous, active-high; clock is clk.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port rx_done  in  1  one-cycle pulse: rx_data holds a new received byte.
REQ-007 SHALL have port rx_data  in  8  received byte, valid only when rx_done=1.
REQ-008 SHALL have port cmd_valid  out  1  one-cycle pulse: a complete, checksum-correct frame was decoded.
REQ-009 SHALL have port cmd_code  out  8  command byte of the last valid frame.
REQ-010 SHALL have port cmd_len  out  3  payload length of the last valid frame.
REQ-011 SHALL have port cmd_payload  out  8*MAX_LEN  payload of the last valid frame, first byte in bits [7:0].
REQ-012 SHALL have port frame_error  out  1  one-cycle pulse: frame discarded (checksum, length or timeout).
REQ-013 SHALL have port busy  out  1  high whenever the state machine is not IDLE.

Function
REQ-014 Frame format SHALL be: sync 0xAA, cmd, len, len payload bytes, chk; chk = XOR of cmd, len and all payload bytes.
REQ-015 States SHALL be IDLE, CMD, LEN, PAYLOAD, CHECK; transitions only on clock edges where rx_done=1, except timeout.
REQ-016 IDLE: rx_done with 0xAA -> CMD; any other byte ignored, no error.
REQ-017 CMD: store byte as pending cmd, init running checksum to byte -> LEN.
REQ-018 LEN: byte > MAX_LEN -> frame_error pulse, IDLE; byte = 0 -> CHECK; else -> PAYLOAD; checksum updated by XOR.
REQ-019 PAYLOAD: store byte at index k (bits [8k+7:8k]), k from 0; after byte len-1 -> CHECK; pending payload bytes not received SHALL be 0.
REQ-020 CHECK: byte = running checksum -> load cmd_code, cmd_len, cmd_payload from pending registers and pulse cmd_valid; else pulse frame_error; both -> IDLE.
REQ-021 Latency: cmd_valid/frame_error SHALL be high during exactly the cycle following the edge that sampled the deciding rx_done.
REQ-022 cmd_code, cmd_len, cmd_payload SHALL change only on a valid frame and hold otherwise, including across errors.
REQ-023 Inter-byte counter SHALL clear on every rx_done and in IDLE, increment otherwise; reaching TIMEOUT_CYCLES in a non-IDLE state -> frame_error pulse, IDLE.
REQ-024 rx_done in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: byte processed, no timeout.
REQ-025 0xAA received mid-frame SHALL be treated as ordinary data, not as resync.
REQ-026 cmd_valid and frame_error SHALL never be high in the same cycle.
REQ-027 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); no wrap before reaching TIMEOUT_CYCLES.

Reset
REQ-028 reset SHALL force IDLE, clear counter, pending registers and checksum, and drive cmd_valid=0, frame_error=0, busy=0, cmd_code=0, cmd_len=0, cmd_payload=0.
REQ-029 reset mid-frame SHALL discard the partial frame with no frame_error pulse; the next frame SHALL decode normally.

Verification
REQ-030 Bytes AA 10 02 34 56 70 -> one cmd_valid pulse, cmd_code=0x10, cmd_len=2, cmd_payload=0x00005634.
REQ-031 Bytes AA 10 02 34 56 71 -> one frame_error pulse, no cmd_valid, outputs keep prior values.
REQ-032 Bytes AA 20 00 20 -> cmd_valid, cmd_code=0x20, cmd_len=0, cmd_payload=0; leading garbage 0x55 before AA ignored.
REQ-033 Bytes AA 10 05 -> frame_error one cycle after the 0x05 byte, busy=0 afterwards.
REQ-034 AA 10 then TIMEOUT_CYCLES with no rx_done -> single frame_error, IDLE; rx_done exactly at the limit cycle -> no error.
REQ-035 reset asserted after AA 10 02 34 -> no pulses, all outputs 0; then full frame of REQ-030 -> cmd_valid with same values.
